// File: rtl/multicycle_cu.sv
// multicycle_cu: multi-cycle control unit for the RV32I core.
// Each instruction moves through FETCH/DECODE/EXEC/MEM/WB. One single-ported
// memory serves both instruction fetch and data access, using a req/ready
// handshake that traps when the memory does not answer in time.
// Optional feature macro: CU_ILLEGAL_TRAP_EN. When it is defined, an illegal
// opcode traps with fault=01. When it is undefined, an illegal opcode retires
// like FENCE.
module multicycle_cu #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] i_opcode,
  input  logic       i_inst_20,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_reg_write,
  output logic       o_branch,
  output logic       o_jump,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_alu_src,
  output logic       o_mux_rd1_pc,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_mem_to_reg,
  output logic [2:0] o_state,
  output logic       o_halted,
  output logic       o_halt_cause,
  output logic [1:0] o_fault
);

  // Timeout counter width. It is kept at least 1 bit wide so that
  // MEM_TIMEOUT=0 (timeout disabled) still elaborates.
  localparam int            CW      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  state_t        r_state, w_next;
  logic [6:0]    r_op;
  logic [1:0]    r_fault, w_fault;
  logic          r_halt_cause, w_halt_cause;
  logic [CW-1:0] r_cnt;
  logic          w_timeout;

`ifdef CU_ILLEGAL_TRAP_EN
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  logic w_legal;
  // Legal opcodes are the listed RV32I major opcodes. All of them have bits[1:0]=11.
  assign w_legal = i_opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                    OP_JAL, OP_JALR, OP_AUIPC, OP_LUI, OP_FENCE,
                                    OP_SYSTEM};
`endif

  // The current request has waited MEM_TIMEOUT cycles and ready is still low. Ready wins a tie.
  assign w_timeout = (MEM_TIMEOUT != 0) && !i_mem_ready && (r_cnt == TO_LAST);

  assign o_state      = r_state;
  assign o_halted     = (r_state == S_HALT) || (r_state == S_TRAP);
  assign o_fault      = r_fault;
  assign o_halt_cause = r_halt_cause;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples values from before the edge, whatever order the blocks run in.
    if (rst) r_state <= S_BOOT;
    else     r_state <= w_next;
  end

  // Latched opcode, plus the sticky fault and halt-cause status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op         <= '0;
      r_fault      <= FAULT_NONE;
      r_halt_cause <= 1'b0;
    end else begin
      if (r_state == S_DECODE) r_op <= i_opcode;
      r_fault      <= w_fault;
      r_halt_cause <= w_halt_cause;
    end
  end

  // Wait counter: counts stalled cycles in FETCH/MEM and clears on any state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if ((r_state == S_FETCH || r_state == S_MEM) && w_next == r_state)
      r_cnt <= r_cnt + CW'(1);
    else
      r_cnt <= '0;
  end

  // Datapath control fields decoded from the latched opcode during EXEC/MEM/WB
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements can leave a value held (no latches).
    o_branch     = 1'b0;
    o_jump       = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_alu_src    = 1'b0;
    o_mux_rd1_pc = 1'b0;
    o_alu_op     = 2'b00;
    o_mem_to_reg = 2'b00;
    if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
      case (r_op)
        OP_R:      o_alu_op = 2'b10;
        OP_I:      begin o_alu_op = 2'b10; o_alu_src = 1'b1; end
        OP_LOAD:   begin o_alu_src = 1'b1; o_mem_read = 1'b1; o_mem_to_reg = 2'b01; end
        OP_STORE:  begin o_alu_src = 1'b1; o_mem_write = 1'b1; end
        OP_BRANCH: begin o_alu_op = 2'b01; o_branch = 1'b1; end
        OP_JAL:    begin o_jump = 1'b1; o_mux_rd1_pc = 1'b1; o_alu_src = 1'b1; o_mem_to_reg = 2'b10; end
        OP_JALR:   begin o_jump = 1'b1; o_alu_src = 1'b1; o_mem_to_reg = 2'b10; end
        OP_AUIPC:  begin o_mux_rd1_pc = 1'b1; o_alu_src = 1'b1; end
        OP_LUI:    begin o_alu_src = 1'b1; o_mem_to_reg = 2'b11; end
        default:   ;  // FENCE, and illegal opcodes that retire as FENCE
      endcase
    end
  end

  // Next state, memory handshake and per-state write strobes
  always_comb begin
    w_next       = r_state;
    w_fault      = r_fault;
    w_halt_cause = r_halt_cause;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_reg_write  = 1'b0;
    case (r_state)
      S_BOOT: w_next = S_FETCH;
      S_FETCH: begin
        o_mem_req = 1'b1;
        if (i_mem_ready) begin
          o_ir_write = 1'b1;
          w_next     = S_DECODE;
        end else if (w_timeout) begin
          w_next  = S_TRAP;
          w_fault = FAULT_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (i_opcode == OP_SYSTEM) begin
          w_next       = S_HALT;
          w_halt_cause = i_inst_20;
        end
`ifdef CU_ILLEGAL_TRAP_EN
        else if (!w_legal) begin
          w_next  = S_TRAP;
          w_fault = FAULT_ILLEGAL;
        end
`endif
        else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (r_op)
          OP_LOAD, OP_STORE:                              w_next = S_MEM;
          OP_R, OP_I, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI:  w_next = S_WB;
          default: begin  // Branch, FENCE, illegal
            o_pc_write = 1'b1;
            w_next     = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        o_mem_req = 1'b1;
        o_mem_we  = (r_op == OP_STORE);
        if (i_mem_ready) begin
          if (r_op == OP_STORE) begin
            o_pc_write = 1'b1;
            w_next     = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (w_timeout) begin
          w_next  = S_TRAP;
          w_fault = FAULT_TIMEOUT;
        end
      end
      S_WB: begin
        o_reg_write = 1'b1;
        o_pc_write  = 1'b1;
        w_next      = S_FETCH;
      end
      default: ;  // HALT and TRAP hold until reset
    endcase
  end

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed testbench for multicycle_cu, built with MEM_TIMEOUT=4.
// Each scenario task drives a table of per-cycle vectors and checks the
// expected state, strobes, fault and halt cause for every cycle.
module tb_multicycle_cu;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  localparam logic [2:0] S_BOOT = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6, S_TRAP = 3'd7;

  // Bit positions of the packed output vector built by outs().
  localparam logic [15:0] MREQ    = 16'h8000, MWE     = 16'h4000, IRW   = 16'h2000,
                          PCW     = 16'h1000, RGW     = 16'h0800, BR    = 16'h0400,
                          JMP     = 16'h0200, MRD     = 16'h0100, MWR   = 16'h0080,
                          ASRC    = 16'h0040, RD1PC   = 16'h0020, AOP_SUB = 16'h0008,
                          AOP_FN  = 16'h0010, M2R_MEM = 16'h0002, M2R_PC4 = 16'h0004,
                          M2R_IMM = 16'h0006, HLT     = 16'h0001;

  localparam logic [15:0] F_LOAD = ASRC | MRD | M2R_MEM;

  typedef struct {
    logic        rdy;
    logic [6:0]  opc;
    logic        i20;
    logic [2:0]  st;
    logic [15:0] o;
    logic [1:0]  flt;
    logic        hc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] i_opcode = OP_R;
  logic       i_inst_20 = 1'b0;
  logic       i_mem_ready = 1'b1;
  logic       o_mem_req, o_mem_we, o_ir_write, o_pc_write, o_reg_write;
  logic       o_branch, o_jump, o_mem_read, o_mem_write, o_alu_src, o_mux_rd1_pc;
  logic [1:0] o_alu_op, o_mem_to_reg, o_fault;
  logic [2:0] o_state;
  logic       o_halted, o_halt_cause;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_cu #(.MEM_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_opcode     (i_opcode),
    .i_inst_20    (i_inst_20),
    .i_mem_ready  (i_mem_ready),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_ir_write   (o_ir_write),
    .o_pc_write   (o_pc_write),
    .o_reg_write  (o_reg_write),
    .o_branch     (o_branch),
    .o_jump       (o_jump),
    .o_mem_read   (o_mem_read),
    .o_mem_write  (o_mem_write),
    .o_alu_src    (o_alu_src),
    .o_mux_rd1_pc (o_mux_rd1_pc),
    .o_alu_op     (o_alu_op),
    .o_mem_to_reg (o_mem_to_reg),
    .o_state      (o_state),
    .o_halted     (o_halted),
    .o_halt_cause (o_halt_cause),
    .o_fault      (o_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] outs();
    return {o_mem_req, o_mem_we, o_ir_write, o_pc_write, o_reg_write, o_branch, o_jump,
            o_mem_read, o_mem_write, o_alu_src, o_mux_rd1_pc, o_alu_op, o_mem_to_reg, o_halted};
  endfunction

  function automatic vec_t mk(input logic rdy, input logic [6:0] opc, input logic i20,
                              input logic [2:0] st, input logic [15:0] o,
                              input logic [1:0] flt, input logic hc);
    vec_t v;
    v.rdy = rdy; v.opc = opc; v.i20 = i20; v.st = st; v.o = o; v.flt = flt; v.hc = hc;
    return v;
  endfunction

  // Reset asserted at time 0; check BOOT outputs with ready high, then release.
  task automatic test_reset();
    rst = 1'b1; i_mem_ready = 1'b1; i_opcode = OP_R; i_inst_20 = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (o_state !== S_BOOT || outs() !== 16'h0 || o_fault !== 2'b00 || o_halt_cause !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: state=%0d outs=%h fault=%b hc=%b, expected 0/0000/00/0",
               o_state, outs(), o_fault, o_halt_cause);
    end
    rst = 1'b0;
  endtask

  // Asynchronous reset pulse: everything must drop before the next clock edge.
  task automatic reset_pulse(input string name);
    rst = 1'b1;
    #2;
    n_tests++;
    if (o_state !== S_BOOT || outs() !== 16'h0 || o_fault !== 2'b00 || o_halt_cause !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: state=%0d outs=%h fault=%b hc=%b, expected 0/0000/00/0",
               name, o_state, outs(), o_fault, o_halt_cause);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_r_type();
    vec_t v[$];
    v.push_back(mk(1, OP_R, 0, S_BOOT,   16'h0,              2'b00, 0));
    v.push_back(mk(1, OP_R, 0, S_FETCH,  MREQ | IRW,         2'b00, 0));
    v.push_back(mk(1, OP_R, 0, S_DECODE, 16'h0,              2'b00, 0));
    v.push_back(mk(1, OP_R, 0, S_EXEC,   AOP_FN,             2'b00, 0));
    v.push_back(mk(1, OP_R, 0, S_WB,     AOP_FN | RGW | PCW, 2'b00, 0));
    foreach (v[i]) begin
      i_mem_ready = v[i].rdy; i_opcode = v[i].opc; i_inst_20 = v[i].i20;
      #2;
      n_tests++;
      if (o_state !== v[i].st || outs() !== v[i].o || o_fault !== v[i].flt || o_halt_cause !== v[i].hc) begin
        n_fail++;
        $display("FAIL r_type[%0d]: state=%0d outs=%h fault=%b hc=%b, expected state=%0d outs=%h fault=%b hc=%b",
                 i, o_state, outs(), o_fault, o_halt_cause, v[i].st, v[i].o, v[i].flt, v[i].hc);
      end
      @(posedge clk); #1;
    end
  endtask

  // Load with ready low for two MEM cycles: 7 cycles from FETCH to FETCH.
  task automatic test_load_stall();
    vec_t v[$];
    v.push_back(mk(1, OP_LOAD, 0, S_FETCH,  MREQ | IRW,         2'b00, 0));
    v.push_back(mk(1, OP_LOAD, 0, S_DECODE, 16'h0,              2'b00, 0));
    v.push_back(mk(1, OP_LOAD, 0, S_EXEC,   F_LOAD,             2'b00, 0));
    v.push_back(mk(0, OP_LOAD, 0, S_MEM,    MREQ | F_LOAD,      2'b00, 0));
    v.push_back(mk(0, OP_LOAD, 0, S_MEM,    MREQ | F_LOAD,      2'b00, 0));
    v.push_back(mk(1, OP_LOAD, 0, S_MEM,    MREQ | F_LOAD,      2'b00, 0));
    v.push_back(mk(1, OP_LOAD, 0, S_WB,     F_LOAD | RGW | PCW, 2'b00, 0));
    v.push_back(mk(1, OP_R,    0, S_FETCH,  MREQ | IRW,         2'b00, 0));
    foreach (v[i]) begin
      i_mem_ready = v[i].rdy; i_opcode = v[i].opc; i_inst_20 = v[i].i20;
      #2;
      n_tests++;
      if (o_state !== v[i].st || outs() !== v[i].o || o_fault !== v[i].flt || o_halt_cause !== v[i].hc) begin
        n_fail++;
        $display("FAIL load_stall[%0d]: state=%0d outs=%h fault=%b hc=%b, expected state=%0d outs=%h fault=%b hc=%b",
                 i, o_state, outs(), o_fault, o_halt_cause, v[i].st, v[i].o, v[i].flt, v[i].hc);
      end
      @(posedge clk); #1;
    end
    // The extra FETCH above let an R-type start; finish it.
    v.delete();
    v.push_back(mk(1, OP_R, 0, S_DECODE, 16'h0,              2'b00, 0));
    v.push_back(mk(1, OP_R, 0, S_EXEC,   AOP_FN,             2'b00, 0));
    v.push_back(mk(1, OP_R, 0, S_WB,     AOP_FN | RGW | PCW, 2'b00, 0));
    foreach (v[i]) begin
      i_mem_ready = v[i].rdy; i_opcode = v[i].opc; i_inst_20 = v[i].i20;
      #2;
      n_tests++;
      if (o_state !== v[i].st || outs() !== v[i].o || o_fault !== v[i].flt || o_halt_cause !== v[i].hc) begin
        n_fail++;
        $display("FAIL load_tail[%0d]: state=%0d outs=%h fault=%b hc=%b, expected state=%0d outs=%h fault=%b hc=%b",
                 i, o_state, outs(), o_fault, o_halt_cause, v[i].st, v[i].o, v[i].flt, v[i].hc);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_branch();
    vec_t v[$];
    v.push_back(mk(1, OP_STORE,  0, S_FETCH,  MREQ | IRW,                    2'b00, 0));
    v.push_back(mk(1, OP_STORE,  0, S_DECODE, 16'h0,                         2'b00, 0));
    v.push_back(mk(1, OP_STORE,  0, S_EXEC,   ASRC | MWR,                    2'b00, 0));
    v.push_back(mk(1, OP_STORE,  0, S_MEM,    MREQ | MWE | ASRC | MWR | PCW, 2'b00, 0));
    v.push_back(mk(1, OP_BRANCH, 0, S_FETCH,  MREQ | IRW,                    2'b00, 0));
    v.push_back(mk(1, OP_BRANCH, 0, S_DECODE, 16'h0,                         2'b00, 0));
    v.push_back(mk(1, OP_BRANCH, 0, S_EXEC,   BR | AOP_SUB | PCW,            2'b00, 0));
    foreach (v[i]) begin
      i_mem_ready = v[i].rdy; i_opcode = v[i].opc; i_inst_20 = v[i].i20;
      #2;
      n_tests++;
      if (o_state !== v[i].st || outs() !== v[i].o || o_fault !== v[i].flt || o_halt_cause !== v[i].hc) begin
        n_fail++;
        $display("FAIL store_branch[%0d]: state=%0d outs=%h fault=%b hc=%b, expected state=%0d outs=%h fault=%b hc=%b",
                 i, o_state, outs(), o_fault, o_halt_cause, v[i].st, v[i].o, v[i].flt, v[i].hc);
      end
      @(posedge clk); #1;
    end
  endtask

  // I, JAL, JALR, AUIPC and LUI back to back, then a FENCE.
  task automatic test_back_to_back();
    vec_t v[$];
    logic [6:0]  opcs [5];
    logic [15:0] flds [5];
    opcs[0] = OP_I;     flds[0] = AOP_FN | ASRC;
    opcs[1] = OP_JAL;   flds[1] = JMP | RD1PC | ASRC | M2R_PC4;
    opcs[2] = OP_JALR;  flds[2] = JMP | ASRC | M2R_PC4;
    opcs[3] = OP_AUIPC; flds[3] = RD1PC | ASRC;
    opcs[4] = OP_LUI;   flds[4] = ASRC | M2R_IMM;
    for (int k = 0; k < 5; k++) begin
      v.push_back(mk(1, opcs[k], 0, S_FETCH,  MREQ | IRW,            2'b00, 0));
      v.push_back(mk(1, opcs[k], 0, S_DECODE, 16'h0,                 2'b00, 0));
      v.push_back(mk(1, opcs[k], 0, S_EXEC,   flds[k],               2'b00, 0));
      v.push_back(mk(1, opcs[k], 0, S_WB,     flds[k] | RGW | PCW,   2'b00, 0));
    end
    v.push_back(mk(1, OP_FENCE, 0, S_FETCH,  MREQ | IRW, 2'b00, 0));
    v.push_back(mk(1, OP_FENCE, 0, S_DECODE, 16'h0,      2'b00, 0));
    v.push_back(mk(1, OP_FENCE, 0, S_EXEC,   PCW,        2'b00, 0));
    foreach (v[i]) begin
      i_mem_ready = v[i].rdy; i_opcode = v[i].opc; i_inst_20 = v[i].i20;
      #2;
      n_tests++;
      if (o_state !== v[i].st || outs() !== v[i].o || o_fault !== v[i].flt || o_halt_cause !== v[i].hc) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: state=%0d outs=%h fault=%b hc=%b, expected state=%0d outs=%h fault=%b hc=%b",
                 i, o_state, outs(), o_fault, o_halt_cause, v[i].st, v[i].o, v[i].flt, v[i].hc);
      end
      @(posedge clk); #1;
    end
  endtask

  // Reset lands in the middle of a stalled load access.
  task automatic test_mid_reset();
    vec_t v[$];
    v.push_back(mk(1, OP_LOAD, 0, S_FETCH,  MREQ | IRW,    2'b00, 0));
    v.push_back(mk(1, OP_LOAD, 0, S_DECODE, 16'h0,         2'b00, 0));
    v.push_back(mk(1, OP_LOAD, 0, S_EXEC,   F_LOAD,        2'b00, 0));
    v.push_back(mk(0, OP_LOAD, 0, S_MEM,    MREQ | F_LOAD, 2'b00, 0));
    foreach (v[i]) begin
      i_mem_ready = v[i].rdy; i_opcode = v[i].opc; i_inst_20 = v[i].i20;
      #2;
      n_tests++;
      if (o_state !== v[i].st || outs() !== v[i].o || o_fault !== v[i].flt || o_halt_cause !== v[i].hc) begin
        n_fail++;
        $display("FAIL mid_reset[%0d]: state=%0d outs=%h fault=%b hc=%b, expected state=%0d outs=%h fault=%b hc=%b",
                 i, o_state, outs(), o_fault, o_halt_cause, v[i].st, v[i].o, v[i].flt, v[i].hc);
      end
      @(posedge clk); #1;
    end
    reset_pulse("mid_reset_async");
  endtask

  task automatic test_illegal();
    vec_t v[$];
    v.push_back(mk(1, OP_BAD, 0, S_BOOT,   16'h0,      2'b00, 0));
    v.push_back(mk(1, OP_BAD, 0, S_FETCH,  MREQ | IRW, 2'b00, 0));
    v.push_back(mk(1, OP_BAD, 0, S_DECODE, 16'h0,      2'b00, 0));
`ifdef CU_ILLEGAL_TRAP_EN
    v.push_back(mk(1, OP_BAD, 0, S_TRAP,   HLT,        2'b01, 0));
    v.push_back(mk(1, OP_BAD, 0, S_TRAP,   HLT,        2'b01, 0));
`else
    v.push_back(mk(1, OP_BAD, 0, S_EXEC,   PCW,        2'b00, 0));
    v.push_back(mk(1, OP_BAD, 0, S_FETCH,  MREQ | IRW, 2'b00, 0));
`endif
    foreach (v[i]) begin
      i_mem_ready = v[i].rdy; i_opcode = v[i].opc; i_inst_20 = v[i].i20;
      #2;
      n_tests++;
      if (o_state !== v[i].st || outs() !== v[i].o || o_fault !== v[i].flt || o_halt_cause !== v[i].hc) begin
        n_fail++;
        $display("FAIL illegal[%0d]: state=%0d outs=%h fault=%b hc=%b, expected state=%0d outs=%h fault=%b hc=%b",
                 i, o_state, outs(), o_fault, o_halt_cause, v[i].st, v[i].o, v[i].flt, v[i].hc);
      end
      @(posedge clk); #1;
    end
    reset_pulse("illegal_reset");
  endtask

  // FETCH with no ready for 4 cycles traps; ready on the 4th cycle completes normally.
  task automatic test_fetch_timeout();
    vec_t v[$];
    v.push_back(mk(0, OP_FENCE, 0, S_BOOT,  16'h0, 2'b00, 0));
    for (int k = 0; k < 4; k++) v.push_back(mk(0, OP_FENCE, 0, S_FETCH, MREQ, 2'b00, 0));
    v.push_back(mk(1, OP_FENCE, 0, S_TRAP,  HLT,   2'b10, 0));
    v.push_back(mk(1, OP_FENCE, 0, S_TRAP,  HLT,   2'b10, 0));
    foreach (v[i]) begin
      i_mem_ready = v[i].rdy; i_opcode = v[i].opc; i_inst_20 = v[i].i20;
      #2;
      n_tests++;
      if (o_state !== v[i].st || outs() !== v[i].o || o_fault !== v[i].flt || o_halt_cause !== v[i].hc) begin
        n_fail++;
        $display("FAIL fetch_timeout[%0d]: state=%0d outs=%h fault=%b hc=%b, expected state=%0d outs=%h fault=%b hc=%b",
                 i, o_state, outs(), o_fault, o_halt_cause, v[i].st, v[i].o, v[i].flt, v[i].hc);
      end
      @(posedge clk); #1;
    end
    reset_pulse("fetch_timeout_reset");
    v.delete();
    v.push_back(mk(0, OP_FENCE, 0, S_BOOT,   16'h0, 2'b00, 0));
    for (int k = 0; k < 3; k++) v.push_back(mk(0, OP_FENCE, 0, S_FETCH, MREQ, 2'b00, 0));
    v.push_back(mk(1, OP_FENCE, 0, S_FETCH,  MREQ | IRW, 2'b00, 0));
    v.push_back(mk(0, OP_FENCE, 0, S_DECODE, 16'h0,      2'b00, 0));
    v.push_back(mk(0, OP_FENCE, 0, S_EXEC,   PCW,        2'b00, 0));
    foreach (v[i]) begin
      i_mem_ready = v[i].rdy; i_opcode = v[i].opc; i_inst_20 = v[i].i20;
      #2;
      n_tests++;
      if (o_state !== v[i].st || outs() !== v[i].o || o_fault !== v[i].flt || o_halt_cause !== v[i].hc) begin
        n_fail++;
        $display("FAIL fetch_ready_tie[%0d]: state=%0d outs=%h fault=%b hc=%b, expected state=%0d outs=%h fault=%b hc=%b",
                 i, o_state, outs(), o_fault, o_halt_cause, v[i].st, v[i].o, v[i].flt, v[i].hc);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_timeout();
    vec_t v[$];
    v.push_back(mk(1, OP_LOAD, 0, S_FETCH,  MREQ | IRW, 2'b00, 0));
    v.push_back(mk(0, OP_LOAD, 0, S_DECODE, 16'h0,      2'b00, 0));
    v.push_back(mk(0, OP_LOAD, 0, S_EXEC,   F_LOAD,     2'b00, 0));
    for (int k = 0; k < 4; k++) v.push_back(mk(0, OP_LOAD, 0, S_MEM, MREQ | F_LOAD, 2'b00, 0));
    v.push_back(mk(1, OP_LOAD, 0, S_TRAP,   HLT,        2'b10, 0));
    foreach (v[i]) begin
      i_mem_ready = v[i].rdy; i_opcode = v[i].opc; i_inst_20 = v[i].i20;
      #2;
      n_tests++;
      if (o_state !== v[i].st || outs() !== v[i].o || o_fault !== v[i].flt || o_halt_cause !== v[i].hc) begin
        n_fail++;
        $display("FAIL mem_timeout[%0d]: state=%0d outs=%h fault=%b hc=%b, expected state=%0d outs=%h fault=%b hc=%b",
                 i, o_state, outs(), o_fault, o_halt_cause, v[i].st, v[i].o, v[i].flt, v[i].hc);
      end
      @(posedge clk); #1;
    end
    reset_pulse("mem_timeout_reset");
  endtask

  // EBREAK halts; later ready pulses produce no strobes; reset clears halt_cause.
  task automatic test_halt();
    vec_t v[$];
    v.push_back(mk(1, OP_SYSTEM, 1, S_BOOT,   16'h0,      2'b00, 0));
    v.push_back(mk(1, OP_SYSTEM, 1, S_FETCH,  MREQ | IRW, 2'b00, 0));
    v.push_back(mk(1, OP_SYSTEM, 1, S_DECODE, 16'h0,      2'b00, 0));
    v.push_back(mk(1, OP_SYSTEM, 0, S_HALT,   HLT,        2'b00, 1));
    v.push_back(mk(0, OP_R,      0, S_HALT,   HLT,        2'b00, 1));
    v.push_back(mk(1, OP_LOAD,   0, S_HALT,   HLT,        2'b00, 1));
    foreach (v[i]) begin
      i_mem_ready = v[i].rdy; i_opcode = v[i].opc; i_inst_20 = v[i].i20;
      #2;
      n_tests++;
      if (o_state !== v[i].st || outs() !== v[i].o || o_fault !== v[i].flt || o_halt_cause !== v[i].hc) begin
        n_fail++;
        $display("FAIL halt[%0d]: state=%0d outs=%h fault=%b hc=%b, expected state=%0d outs=%h fault=%b hc=%b",
                 i, o_state, outs(), o_fault, o_halt_cause, v[i].st, v[i].o, v[i].flt, v[i].hc);
      end
      @(posedge clk); #1;
    end
    reset_pulse("halt_reset");
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_load_stall();
    test_store_branch();
    test_back_to_back();
    test_mid_reset();
    test_illegal();
    test_fetch_timeout();
    test_mem_timeout();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
